// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave burst bridge.
//   - FSM state encodings (IDLE / CMD / DATA)
//   - R/W command bit values
//   - bit positions inside the sticky err vector
package spi_slave_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERRUN  = 1;

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchroniser and SPI edge strobe generator.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sclk, cs_n, sdi   raw SPI pins
//   cs_act            synchronised chip select, 1 = frame active
//   cs_fall           one-cycle pulse on chip-select assertion
//   sample, shift     one-cycle pulses on the sample / shift SCLK edge
//   sdi_bit           sdi value aligned with the sample strobe
// Every output is registered once after the last synchroniser stage, so a
// pin edge reaches the strobes SYNC_STAGES+1 clk cycles later.
module spi_pin_sync #(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic sdi,
  output logic cs_act,
  output logic cs_fall,
  output logic sample,
  output logic shift,
  output logic sdi_bit
);

  localparam logic IDLE_LVL    = (CPOL != 0);
  // Leading edge is the rising one when CPOL=0; sampling on the leading edge
  // when CPHA=0 makes the sample edge rising exactly when CPOL==CPHA.
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  logic [SYNC_STAGES-1:0] sclk_q, cs_q, sdi_q;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, rise, fall;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev;
  assign fall   = ~sclk_s & sclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset to idle pin levels so no spurious edge appears on release.
      sclk_q    <= {SYNC_STAGES{IDLE_LVL}};
      cs_q      <= '1;
      sdi_q     <= '0;
      sclk_prev <= IDLE_LVL;
      cs_prev   <= 1'b1;
      cs_act    <= 1'b0;
      cs_fall   <= 1'b0;
      sample    <= 1'b0;
      shift     <= 1'b0;
      sdi_bit   <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sdi_q     <= {sdi_q[SYNC_STAGES-2:0], sdi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      cs_act    <= ~cs_s;
      cs_fall   <= ~cs_s & cs_prev;
      sample    <= SAMPLE_RISE ? rise : fall;
      shift     <= SAMPLE_RISE ? fall : rise;
      sdi_bit   <= sdi_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave to register-bus bridge with auto-increment bursts.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   cs_n, sclk, sdi         SPI pins (any mode via CPOL/CPHA)
//   sdo, sdo_oe             serial read data and its tri-state enable
//   addr, wr_en, rd_en      bus request; requests held until rdy
//   data_wr, data_rd, rdy   bus write data, read data, completion
//   busy                    synchronised chip select is active
//   err                     sticky [0] read underrun, [1] write overrun
// Frame: R/W bit (1 = read), ADDR_WIDTH address bits, then any number of
// DATA_WIDTH words; the address advances after each completed access.
module spi_slave_burst
  import spi_slave_pkg::*;
#(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sclk,
  input  logic                  sdi,
  output logic                  sdo,
  output logic                  sdo_oe,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_wr,
  input  logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  rdy,
  output logic                  busy,
  output logic [1:0]            err
);

  localparam int BITS_MAX = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW       = $clog2(BITS_MAX);
  localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam bit LSBF = (LSB_FIRST != 0);

  logic cs_act, cs_fall, sample, shift, sdi_bit;

  spi_pin_sync #(
    .CPOL       (CPOL),
    .CPHA       (CPHA),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .sdi    (sdi),
    .cs_act (cs_act),
    .cs_fall(cs_fall),
    .sample (sample),
    .shift  (shift),
    .sdi_bit(sdi_bit)
  );

  logic [1:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr_sr, addr_nxt;
  logic [DATA_WIDTH-1:0] rx_sr, rx_nxt;
  logic [DATA_WIDTH-1:0] tx_sr, tx_adv;
  logic [DATA_WIDTH-1:0] rd_buf, word_src, word_rest;
  logic                  buf_valid, late, refetch, sdo_q;
  logic                  rd_frame, word_ok, first_bit, tx_bit;

  assign rd_frame = (rw == RW_READ) && (state == ST_DATA) && cs_act;
  assign sdo_oe   = rd_frame;
  assign sdo      = rd_frame & sdo_q;
  assign busy     = cs_act;

  // A response landing in the same cycle as the first shift edge still
  // counts as on time; it bypasses the holding buffer.
  assign word_ok  = buf_valid || (rd_en && rdy && !late);
  assign word_src = buf_valid ? rd_buf : data_rd;

  always_comb begin
    addr_nxt  = LSBF ? {sdi_bit, addr_sr[ADDR_WIDTH-1:1]} : {addr_sr[ADDR_WIDTH-2:0], sdi_bit};
    rx_nxt    = LSBF ? {sdi_bit, rx_sr[DATA_WIDTH-1:1]}   : {rx_sr[DATA_WIDTH-2:0], sdi_bit};
    first_bit = LSBF ? word_src[0] : word_src[DATA_WIDTH-1];
    word_rest = LSBF ? {1'b1, word_src[DATA_WIDTH-1:1]} : {word_src[DATA_WIDTH-2:0], 1'b1};
    tx_bit    = LSBF ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
    tx_adv    = LSBF ? {1'b1, tx_sr[DATA_WIDTH-1:1]} : {tx_sr[DATA_WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rw        <= RW_WRITE;
      addr_sr   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rd_buf    <= '0;
      buf_valid <= 1'b0;
      late      <= 1'b0;
      refetch   <= 1'b0;
      sdo_q     <= 1'b0;
      addr      <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      data_wr   <= '0;
      err       <= '0;
    end else begin
      // Bus completions; rdy with nothing pending falls through untouched.
      if (wr_en && rdy) begin
        wr_en <= 1'b0;
        addr  <= addr + 1'b1;
      end
      if (rd_en && rdy) begin
        rd_en <= 1'b0;
        addr  <= addr + 1'b1;
        if (late) begin
          // Data for a word already sent as all-ones: drop it and fetch the
          // next word straight away so the underrun does not cascade.
          late    <= 1'b0;
          refetch <= rd_frame;
        end else if (rd_frame) begin
          rd_buf    <= data_rd;
          buf_valid <= 1'b1;
        end
      end
      if (refetch) begin
        refetch <= 1'b0;
        if (rd_frame) rd_en <= 1'b1;
      end

      if (cs_fall) begin
        state     <= ST_CMD;
        bit_cnt   <= '0;
        err       <= '0;
        buf_valid <= 1'b0;
        late      <= 1'b0;
        refetch   <= 1'b0;
        sdo_q     <= 1'b0;
      end else if (!cs_act) begin
        // Partial words are simply abandoned; pending requests finish alone.
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sdo_q   <= 1'b0;
      end else begin
        case (state)
          ST_CMD: begin
            if (sample) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == '0) rw <= sdi_bit;
              else addr_sr <= addr_nxt;
              if (bit_cnt == CMD_LAST) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
                addr    <= addr_nxt;
                if (rw == RW_READ) rd_en <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (rw == RW_READ) begin
              if (shift) begin
                if (bit_cnt == '0) begin
                  if (word_ok) begin
                    sdo_q     <= first_bit;
                    tx_sr     <= word_rest;
                    buf_valid <= 1'b0;
                    rd_en     <= 1'b1;   // prefetch the following word
                  end else begin
                    sdo_q            <= 1'b1;
                    tx_sr            <= '1;
                    err[ERR_UNDERRUN] <= 1'b1;
                    if (rd_en) late  <= 1'b1;
                    else rd_en       <= 1'b1;
                  end
                end else begin
                  sdo_q <= tx_bit;
                  tx_sr <= tx_adv;
                end
              end
              if (sample) bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
            end else if (sample) begin
              rx_sr <= rx_nxt;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (wr_en && !rdy) begin
                  err[ERR_OVERRUN] <= 1'b1;
                end else begin
                  data_wr <= rx_nxt;
                  wr_en   <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_burst.md
# spi_slave_burst

Parametrised SPI slave-to-register-bus bridge; successor to the fixed-mode single-word SPI slave. Supports all four SPI modes, MSB/LSB-first framing and auto-incrementing burst transfers. Adds read prefetch, a tri-state enable for 3-wire wiring, and sticky error reporting. Sits between the external SPI pins and the on-chip register bus, in the `clk` domain.

## Interface
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `ADDR_WIDTH`, 16: register address bits; ≥ 2.
- `DATA_WIDTH`, 16: data word bits; ≥ 2.
- `LSB_FIRST`, 0: 1 = shift address and data LSB first; the R/W bit is always first.
- `SYNC_STAGES`, 2: synchroniser depth for `sclk`, `cs_n`, `sdi`; ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cs_n` in 1: SPI chip select, active low.
- `sclk` in 1: SPI clock.
- `sdi` in 1: serial data in.
- `sdo` out 1: serial data out.
- `sdo_oe` out 1: output enable; high only while driving read data.
- `addr` out ADDR_WIDTH: bus address.
- `wr_en` out 1: write request; held until `rdy`.
- `rd_en` out 1: read request; held until `rdy`.
- `data_wr` out DATA_WIDTH: write data.
- `data_rd` in DATA_WIDTH: read data, valid with `rdy`.
- `rdy` in 1: bus completion for the pending request.
- `busy` out 1: frame active, i.e. synchronised `cs_n` is low.
- `err` out 2: sticky flags; [0] read underrun, [1] write overrun. Cleared by the next `cs_n` falling edge.

## Operation
- Sample edge is rising if `CPOL == CPHA`, else falling. Shift edge is the opposite edge.
- Frame layout: R/W bit (1 = read), then ADDR_WIDTH address bits, then N ≥ 0 data words.
- States:
  - IDLE → CMD on `cs_n` fall.
  - CMD → DATA after ADDR_WIDTH+1 sample edges.
  - DATA loops per word.
  - Any state → IDLE on `cs_n` rise.
- Bit counter width is `$clog2(max(ADDR_WIDTH+1, DATA_WIDTH))`. It clears at each state/word boundary.
- Write word: after the DATA_WIDTH-th sample edge, load `data_wr` and assert `wr_en` with the current `addr`. On `rdy`, drop `wr_en` and increment `addr`; the increment wraps modulo 2^ADDR_WIDTH.
- Write overrun: if the next word completes while `wr_en` is still high, drop the new word and set `err[1]`.
- Read: assert `rd_en` the cycle after the last address bit is sampled. On `rdy`, load the shift register, drop `rd_en` and increment `addr`.
  - The next read (prefetch) issues when the first bit of the current word is shifted out.
- Read underrun: if the shift register is not loaded by the first shift edge of a word, shift all-ones and set `err[0]`. Late data for that word is discarded.
- Drive `sdo` on each shift edge during DATA of a read frame. `sdo_oe` = read frame && DATA && `!cs_n`; otherwise `sdo` = 0.
- `cs_n` rise mid-frame: discard the partial word and issue no new requests. An already pending `wr_en`/`rd_en` stays high until `rdy`.
- `rdy` while no request is pending is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; `err` = 0.
- Input latency: `SYNC_STAGES`+1 `clk` cycles from a pin edge to the internal strobe.
- `clk` must be ≥ 8× `sclk`.
- Read budget for the first word: `rdy` must arrive within (clk/sclk)/2 − `SYNC_STAGES` − 2 cycles after `rd_en` rises. Later words have a full word time.
- `wr_en` rises 1 cycle after the internal sample strobe of the last data bit.
- `sdo` updates 1 cycle after the internal shift strobe.

## Structure
- `spi_slave_pkg`: state enum {IDLE, CMD, DATA}, R/W bit constants, `err` bit indices.
- Sub-module `spi_pin_sync`: synchroniser for the `sclk`, `cs_n` and `sdi` inputs, plus sample/shift strobe generation from CPOL/CPHA.

## Test plan
- Mode 0, MSB-first, write to 0x0012 with data 0xA5C3 → one `wr_en` with `addr`=0x0012, `data_wr`=0xA5C3; `err`=0.
- Mode 3, 3-word burst write from 0xFFFF, `rdy` after 2 cycles → writes to 0xFFFF, 0x0000, 0x0001.
- Mode 1, read from 0x0040, bus returns 0x1234 after 1 cycle → `sdo` shifts 0x1234; `sdo_oe` high for exactly 16 bits.
- Read with `rdy` withheld past the budget → word reads 0xFFFF; `err[0]`=1, cleared at the next frame.
- Burst write with `rdy` held low for 2 words → second word dropped; `err[1]`=1.
- `cs_n` raised after 5 data bits, then `rst_n` pulsed during a pending `wr_en` → no write issued for the partial word; all outputs return to 0 immediately on reset.
